// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: issues word requests, buffers {pc, instruction pair} in a 2-entry FIFO.
// Optional IFU_STARVE_CNT_EN adds a saturating starve_cnt output counting cycles without a valid pair.
module if_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [15:0] instr_set1,
    output logic [15:0] instr_set2,
    output logic [31:0] pc_out,
    output logic        valid_out,
    output logic        flush_out,
`ifdef IFU_STARVE_CNT_EN
    output logic [31:0] starve_cnt,
`endif
    output logic [1:0]  fsmState
);

    // Memory handshake: imem_req stays high with a stable imem_addr until the
    // single-cycle imem_ack, which may arrive in the same cycle the request rises.
    typedef enum logic [1:0] {FETCH = 2'd0, WAIT = 2'd1, HOLD = 2'd2, DISCARD = 2'd3} state_t;

    state_t      state, nextState;
    logic [31:0] fetchPc;
    logic [31:0] discardAddr;
    logic [31:0] pcMem   [2];
    logic [31:0] pairMem [2];
    logic        headPtr;
    logic [1:0]  count;
    logic [1:0]  countNext;
    logic        ackSeen;
    logic        accept;
    logic        pop;
    logic        wrIdx;

    assign ackSeen   = imem_ack && (state != HOLD);
    assign accept    = ackSeen && (state != DISCARD) && !redirect;
    assign pop       = valid_out && !stall && !redirect;
    assign countNext = redirect ? 2'd0 : (count + {1'b0, accept} - {1'b0, pop});
    assign wrIdx     = headPtr ^ count[0];

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= nextState;
    end

    // A new request is only allowed when the post-cycle FIFO count leaves room,
    // so every acked pair is guaranteed a free slot.
    always_comb begin
        nextState = state;
        case (state)
            FETCH, WAIT: begin
                if (redirect)     nextState = ackSeen ? FETCH : DISCARD;
                else if (ackSeen) nextState = (countNext < 2'd2) ? FETCH : HOLD;
                else              nextState = WAIT;
            end
            HOLD:    nextState = (countNext < 2'd2) ? FETCH : HOLD;
            DISCARD: nextState = ackSeen ? FETCH : DISCARD;
            default: nextState = FETCH;
        endcase
    end

    always_comb begin
        imem_req   = !reset && (state != HOLD);
        imem_addr  = (state == DISCARD) ? discardAddr : fetchPc;
        valid_out  = !reset && (count != 2'd0);
        flush_out  = redirect;
        pc_out     = valid_out ? pcMem[headPtr] : 32'h0;
        instr_set1 = valid_out ? pairMem[headPtr][15:0] : 16'h0000;
        instr_set2 = valid_out ? pairMem[headPtr][31:16] : 16'h0000;
        fsmState   = state;
    end

    // fetchPc holds the redirect target while DISCARD keeps the old address on the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetchPc     <= RESET_VECTOR;
            discardAddr <= 32'h0;
            headPtr     <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (redirect)    fetchPc <= redirect_pc;
            else if (accept) fetchPc <= fetchPc + 32'd4;
            if (nextState == DISCARD && state != DISCARD) discardAddr <= fetchPc;
            if (pop) headPtr <= ~headPtr;
            count <= countNext;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pcMem[wrIdx]   <= fetchPc;
            pairMem[wrIdx] <= imem_rdata;
        end
    end

`ifdef IFU_STARVE_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)                                   starve_cnt <= 32'h0;
        else if (!valid_out && starve_cnt != 32'hFFFF_FFFF) starve_cnt <= starve_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus a scoreboard of expected pairs.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [15:0] instr_set1;
  logic [15:0] instr_set2;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        flush_out;
  logic [1:0]  fsm_state;
`ifdef IFU_STARVE_CNT_EN
  logic [31:0] starve_cnt;
`endif

  logic        ack_imm = 1'b0;
  logic        ack_pulse = 1'b0;
  logic        force_data = 1'b0;
  logic [31:0] forced_val = 32'h0;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [31:0] model_pc;
  logic        discarding;

  function automatic logic [31:0] data_fn(input logic [31:0] a);
    return {a[15:0] ^ 16'h1234, a[31:16] ^ a[17:2]};
  endfunction

  assign imem_ack   = imem_req & (ack_imm | ack_pulse);
  assign imem_rdata = force_data ? forced_val : data_fn(imem_addr);

  if_fetch_unit dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_set1(instr_set1), .instr_set2(instr_set2), .pc_out(pc_out),
    .valid_out(valid_out), .flush_out(flush_out),
`ifdef IFU_STARVE_CNT_EN
    .starve_cnt(starve_cnt),
`endif
    .fsmState(fsm_state)
  );

  always #5 clk = ~clk;

  // Scoreboard: pairs are expected in request order; redirects and discarded acks drop data.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      model_pc = 32'h0;
      discarding = 1'b0;
    end else begin
      checks++;
      if (valid_out !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL sb_valid: valid_out=%0b expected %0b", valid_out, exp_q.size() != 0);
      end
      if (valid_out && !stall && !redirect && exp_q.size() != 0) begin
        logic [63:0] e;
        e = exp_q.pop_front();
        checks++;
        if ({pc_out, instr_set2, instr_set1} !== e) begin
          errors++;
          $display("FAIL sb_pair: got pc=%h pair=%h%h expected pc=%h pair=%h",
                   pc_out, instr_set2, instr_set1, e[63:32], e[31:0]);
        end
      end
      if (redirect) begin
        exp_q.delete();
        if (imem_req && !imem_ack) discarding = 1'b1;
        else if (imem_ack)         discarding = 1'b0;
        model_pc = redirect_pc;
      end else if (imem_ack) begin
        if (discarding) begin
          discarding = 1'b0;
        end else begin
          checks++;
          if (imem_addr !== model_pc) begin
            errors++;
            $display("FAIL sb_addr: imem_addr=%h expected %h", imem_addr, model_pc);
          end
          exp_q.push_back({model_pc, data_fn(model_pc)});
          model_pc = model_pc + 32'd4;
        end
      end
    end
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 1 (first cycle with reset low), inputs idle.
  task automatic do_reset;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    ack_imm = 1'b0; ack_pulse = 1'b0; force_data = 1'b0;
    repeat (3) next_cycle;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    ack_imm = 1'b1;
    repeat (2) next_cycle;
    #1;
    checks++;
    if (imem_req !== 1'b0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: req=%0b valid=%0b expected 0 0", imem_req, valid_out);
    end
    checks++;
    if (pc_out !== 32'h0 || instr_set1 !== 16'h0 || instr_set2 !== 16'h0) begin
      errors++;
      $display("FAIL reset_out: pc=%h i1=%h i2=%h expected zeros", pc_out, instr_set1, instr_set2);
    end
    checks++;
    if (fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_fsm: state=%0d expected 0", fsm_state);
    end
  endtask

  task automatic test_stream;
    do_reset;
    ack_imm = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (k - 1))) begin
        errors++;
        $display("FAIL stream_addr: cycle %0d req=%0b addr=%h expected 1 %h", k, imem_req, imem_addr, 32'(4 * (k - 1)));
      end
      checks++;
      if (k == 1 ? (valid_out !== 1'b0) : (valid_out !== 1'b1 || pc_out !== 32'(4 * (k - 2)))) begin
        errors++;
        $display("FAIL stream_out: cycle %0d valid=%0b pc=%h", k, valid_out, pc_out);
      end
      next_cycle;
    end
  endtask

  task automatic test_stall;
    do_reset;
    ack_imm = 1'b1;
    stall = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      #1;
      if (k >= 3) begin
        checks++;
        if (imem_req !== 1'b0 || fsm_state !== 2'd2) begin
          errors++;
          $display("FAIL stall_hold: cycle %0d req=%0b state=%0d expected 0 2", k, imem_req, fsm_state);
        end
        checks++;
        if (valid_out !== 1'b1 || pc_out !== 32'h0 || instr_set1 !== 16'h0000 || instr_set2 !== 16'h1234) begin
          errors++;
          $display("FAIL stall_frozen: cycle %0d valid=%0b pc=%h pair=%h%h", k, valid_out, pc_out, instr_set2, instr_set1);
        end
      end
      next_cycle;
    end
    stall = 1'b0;
    #1;
    checks++;
    if (pc_out !== 32'h0) begin
      errors++;
      $display("FAIL stall_release0: pc=%h expected 00000000", pc_out);
    end
    next_cycle;
    #1;
    checks++;
    if (valid_out !== 1'b1 || pc_out !== 32'h4) begin
      errors++;
      $display("FAIL stall_release1: valid=%0b pc=%h expected 1 00000004", valid_out, pc_out);
    end
  endtask

  task automatic test_discard;
    do_reset;
    ack_imm = 1'b1;
    repeat (2) next_cycle;
    ack_imm = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    #1;
    checks++;
    if (flush_out !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      errors++;
      $display("FAIL disc_flush: flush=%0b req=%0b addr=%h expected 1 1 00000008", flush_out, imem_req, imem_addr);
    end
    next_cycle;
    redirect = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h8 || fsm_state !== 2'd3 || valid_out !== 1'b0) begin
        errors++;
        $display("FAIL disc_held: req=%0b addr=%h state=%0d valid=%0b", imem_req, imem_addr, fsm_state, valid_out);
      end
      next_cycle;
    end
    force_data = 1'b1; forced_val = 32'hDEAD_BEEF; ack_pulse = 1'b1;
    next_cycle;
    force_data = 1'b0; ack_pulse = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL disc_target: req=%0b addr=%h valid=%0b expected 1 00000100 0", imem_req, imem_addr, valid_out);
    end
    ack_imm = 1'b1;
    next_cycle;
    #1;
    checks++;
    if (valid_out !== 1'b1 || pc_out !== 32'h100) begin
      errors++;
      $display("FAIL disc_first: valid=%0b pc=%h expected 1 00000100", valid_out, pc_out);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({instr_set2, instr_set1} === 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL disc_leak: pair=%h%h must not appear", instr_set2, instr_set1);
      end
      next_cycle;
    end
  endtask

  task automatic test_redirect_ack;
    do_reset;
    ack_imm = 1'b1;
    repeat (2) next_cycle;
    redirect = 1'b1; redirect_pc = 32'h40;
    #1;
    checks++;
    if (flush_out !== 1'b1 || imem_ack !== 1'b1) begin
      errors++;
      $display("FAIL rack_flush: flush=%0b ack=%0b expected 1 1", flush_out, imem_ack);
    end
    next_cycle;
    redirect = 1'b0;
    #1;
    checks++;
    if (imem_addr !== 32'h40 || imem_req !== 1'b1 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL rack_addr: addr=%h req=%0b valid=%0b expected 00000040 1 0", imem_addr, imem_req, valid_out);
    end
    next_cycle;
    #1;
    checks++;
    if (valid_out !== 1'b1 || pc_out !== 32'h40) begin
      errors++;
      $display("FAIL rack_first: valid=%0b pc=%h expected 1 00000040", valid_out, pc_out);
    end
  endtask

  task automatic test_wrap;
    do_reset;
    ack_imm = 1'b1;
    next_cycle;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    next_cycle;
    redirect = 1'b0;
    #1;
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_a: addr=%h expected fffffffc", imem_addr);
    end
    next_cycle;
    #1;
    checks++;
    if (imem_addr !== 32'h0 || pc_out !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_b: addr=%h pc=%h expected 00000000 fffffffc", imem_addr, pc_out);
    end
    next_cycle;
    #1;
    checks++;
    if (pc_out !== 32'h0) begin
      errors++;
      $display("FAIL wrap_c: pc=%h expected 00000000", pc_out);
    end
  endtask

  task automatic test_random;
    logic        pend;
    logic [31:0] prev_addr;
    do_reset;
    pend = 1'b0;
    prev_addr = 32'h0;
    for (int k = 0; k < 400; k++) begin
      stall       = ($urandom_range(0, 3) == 0);
      ack_imm     = ($urandom_range(0, 2) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = {$urandom_range(0, 1) == 0 ? 30'h3FFF_FFFE : 30'($urandom), 2'b00};
      #1;
      if (pend) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
          errors++;
          $display("FAIL rand_hold: req=%0b addr=%h expected 1 %h", imem_req, imem_addr, prev_addr);
        end
      end
      pend = imem_req && !imem_ack;
      prev_addr = imem_addr;
      next_cycle;
    end
    stall = 1'b0; redirect = 1'b0; ack_imm = 1'b0;
  endtask

`ifdef IFU_STARVE_CNT_EN
  task automatic test_starve;
    do_reset;
    repeat (10) next_cycle;
    #1;
    checks++;
    if (starve_cnt !== 32'd10) begin
      errors++;
      $display("FAIL starve_release: cnt=%0d expected 10", starve_cnt);
    end
    ack_imm = 1'b1;
    repeat (4) next_cycle;
    checks++;
    if (starve_cnt !== 32'd11) begin
      errors++;
      $display("FAIL starve_hold: cnt=%0d expected 11", starve_cnt);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_discard;
    test_redirect_ack;
    test_wrap;
    test_random;
`ifdef IFU_STARVE_CNT_EN
    test_starve;
`endif
    reset = 1'b1;
    repeat (2) next_cycle;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
